// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider controller.
// Holds ALU op codes, state encoding, drain length and the divider result layout.
package div_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 8;
    localparam int unsigned RES_W   = 2 * DATA_W;

    localparam logic [ALUOP_W-1:0] ALUOP_DIV  = 8'b00011010;
    localparam logic [ALUOP_W-1:0] ALUOP_DIVU = 8'b00011011;

    // Cycles spent in CANCEL so the divider can return to free from any state
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_DONE   = 2'd2,
        ST_CANCEL = 2'd3
    } div_state_e;

    // Divider result bus: {remainder, quotient}
    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quot;
    } div_result_t;

    function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// EX-stage divider controller: issues DIV/DIVU to the multi-cycle divider,
// stalls EX while it runs, and presents the {rem, quot} result as a HI/LO write.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   aluop_i, reg1_i/2_i EX op and operands (dividend, divisor)
//   flush_i             kills the EX instruction
//   ex_stall_i          EX held by another stall source
//   div_result_i/ready  divider result and success strobe
//   div_start_o, div_signed_o, div_opdata1_o/2_o, div_cancel_o  divider handshake
//   stallreq_o          combinational pipeline stall request
//   hilo_we_o, hi_o, lo_o  HI/LO write (we is combinational, data registered)
//   dbz_o               divisor was zero
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [DATA_W-1:0]  reg1_i,
    input  logic [DATA_W-1:0]  reg2_i,
    input  logic               flush_i,
    input  logic               ex_stall_i,
    input  logic [RES_W-1:0]   div_result_i,
    input  logic               div_ready_i,
    output logic               div_start_o,
    output logic               div_signed_o,
    output logic [DATA_W-1:0]  div_opdata1_o,
    output logic [DATA_W-1:0]  div_opdata2_o,
    output logic               div_cancel_o,
    output logic               stallreq_o,
    output logic               hilo_we_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic               dbz_o
);

    div_state_e         state_q, state_d;
    logic               start_q, start_d;
    logic               cancel_q, cancel_d;
    logic               signed_q, signed_d;
    logic               dbz_q, dbz_d;
    logic [DATA_W-1:0]  op1_q, op1_d;
    logic [DATA_W-1:0]  op2_q, op2_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic               div_op_c;
    div_result_t        res_c;

    assign div_op_c = is_div_op(aluop_i);
    assign res_c    = div_result_t'(div_result_i);

    // Next-state, registered-output next values and combinational outputs
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        cancel_d   = 1'b0;
        signed_d   = signed_q;
        dbz_d      = dbz_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        drain_d    = drain_q;
        stallreq_o = 1'b0;
        hilo_we_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (div_op_c && !flush_i) begin
                    stallreq_o = 1'b1;
                    // A stale ready from the previous result blocks a new start
                    if (!div_ready_i) begin
                        op1_d    = reg1_i;
                        op2_d    = reg2_i;
                        signed_d = (aluop_i == ALUOP_DIV);
                        dbz_d    = (reg2_i == '0);
                        start_d  = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq_o = 1'b1;
                if (flush_i) begin
                    start_d  = 1'b0;
                    cancel_d = 1'b1;
                    drain_d  = DRAIN_W'(DRAIN_CYCLES - 1);
                    state_d  = ST_CANCEL;
                end else if (div_ready_i) begin
                    hi_d    = res_c.rem;
                    lo_d    = res_c.quot;
                    start_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hilo_we_o = !flush_i;
                if (flush_i || !ex_stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CANCEL: begin
                // A follow-on divide waits here and issues from IDLE
                stallreq_o = div_op_c && !flush_i;
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
            signed_q <= 1'b0;
            dbz_q    <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cancel_q <= cancel_d;
            signed_q <= signed_d;
            dbz_q    <= dbz_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            drain_q  <= drain_d;
        end
    end

    assign div_start_o   = start_q;
    assign div_cancel_o  = cancel_q;
    assign div_signed_o  = signed_q;
    assign div_opdata1_o = op1_q;
    assign div_opdata2_o = op2_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign dbz_o         = dbz_q;

endmodule
